core_msg_rx: RTL and testbench

CORE_MSG_RX -- requirements
Module: core_msg_rx

---
 rtl/core_msg_rx_pkg.sv | 23 ++
 rtl/core_instr_fifo.sv | 65 ++++++
 rtl/core_msg_rx.sv | 159 +++++++++++++++
 tb/tb_core_msg_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/core_msg_rx_pkg.sv
// Shared types and constants for the per-core message receiver.
// Holds the FSM encoding, the END opcode, the opcode field and the error bits.
package core_msg_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } rx_state_e;

  localparam logic [3:0] CORE_OP_END = 4'hF;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;

  localparam int ERR_COLL = 0;
  localparam int ERR_OVF  = 1;
  localparam int ERR_PROT = 2;

  function automatic logic is_end_op(input logic [15:0] w);
    return w[OP_HI:OP_LO] == CORE_OP_END;
  endfunction

endpackage

// File: rtl/core_instr_fifo.sv
// Instruction FIFO between the scheduler message bus and the core pipeline.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module core_instr_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign count   = cnt_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/core_msg_rx.sv
// Per-core receiver for scheduler messages: task ownership FSM,
// r0 argument buffer and instruction FIFO feeding the core pipeline.
module core_msg_rx
  import core_msg_rx_pkg::*;
#(
  parameter int CORE_ID     = 0,
  parameter int BUS_TO_CORE = 16,
  parameter int INSTR_DEPTH = 32,
  parameter int R0_DEPTH    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BUS_TO_CORE-1:0]      mess_to_core,
  input  logic                        core_mask_loading,
  input  logic                        r0_mask_loading,
  input  logic                        r0_loading,
  input  logic                        instr_loading,
  output logic                        core_reading,
  output logic                        core_ready,
  output logic [15:0]                 instr_data,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  input  logic                        exec_done,
  input  logic [$clog2(R0_DEPTH)-1:0] r0_rd_addr,
  output logic [15:0]                 r0_rd_data,
  output logic [$clog2(R0_DEPTH):0]   r0_cnt,
  output logic [2:0]                  err
);

  localparam int R0_AW = $clog2(R0_DEPTH);
  localparam int F_CW  = $clog2(INSTR_DEPTH) + 1;

  rx_state_e     state_q, state_d;
  logic          selected_q, selected_d;
  logic          r0_sel_q, r0_sel_d;
  logic [R0_AW:0] r0_cnt_q, r0_cnt_d;
  logic [2:0]    err_q, err_d;
  logic [15:0]   r0_mem_q [R0_DEPTH];
  logic          r0_we;

  logic          fifo_push, fifo_pop, fifo_clr;
  logic          fifo_full, fifo_empty;
  logic [F_CW-1:0] fifo_cnt;

  logic [3:0]    strb;
  logic          coll, own;
  logic [15:0]   word;

  assign word = mess_to_core[15:0];
  assign own  = mess_to_core[CORE_ID];
  assign strb = {core_mask_loading, r0_mask_loading,
                 r0_loading, instr_loading};
  assign coll = |(strb & (strb - 4'd1));

  assign fifo_pop    = instr_valid & instr_ready;
  assign instr_valid = ~fifo_empty;
  assign core_ready  = ~selected_q;
  assign r0_cnt      = r0_cnt_q;
  assign r0_rd_data  = r0_mem_q[r0_rd_addr];
  assign err         = err_q;

  // Three-entry headroom absorbs strobes already in the scheduler pipe.
  assign core_reading = (state_q != ST_LOAD) ||
                        (fifo_cnt <= F_CW'(INSTR_DEPTH - 3));

  core_instr_fifo #(
    .DEPTH (INSTR_DEPTH),
    .W     (16)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .din   (word),
    .pop   (fifo_pop),
    .dout  (instr_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    selected_d = selected_q;
    r0_sel_d   = r0_sel_q;
    r0_cnt_d   = r0_cnt_q;
    err_d      = err_q;
    fifo_push  = 1'b0;
    fifo_clr   = 1'b0;
    r0_we      = 1'b0;
    if (coll) err_d[ERR_COLL] = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (core_mask_loading && own) begin
          state_d    = ST_LOAD;
          selected_d = 1'b1;
          r0_sel_d   = 1'b0;
          r0_cnt_d   = '0;
          fifo_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (core_mask_loading) begin
          if (own) err_d[ERR_PROT] = 1'b1;
        end else if (r0_mask_loading) begin
          r0_sel_d = own;
        end else if (r0_loading) begin
          if (r0_sel_q) begin
            if (r0_cnt_q == (R0_AW+1)'(R0_DEPTH)) begin
              err_d[ERR_OVF] = 1'b1;
            end else begin
              r0_we    = 1'b1;
              r0_cnt_d = r0_cnt_q + 1'b1;
            end
          end
        end else if (instr_loading) begin
          if (is_end_op(word)) begin
            state_d = ST_FINISH;
          end else begin
            fifo_push = 1'b1;
            if (fifo_full && !fifo_pop) err_d[ERR_OVF] = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        if (core_mask_loading && own) err_d[ERR_PROT] = 1'b1;
        if (exec_done && fifo_empty) begin
          state_d    = ST_IDLE;
          selected_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        selected_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      selected_q <= 1'b0;
      r0_sel_q   <= 1'b0;
      r0_cnt_q   <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      selected_q <= selected_d;
      r0_sel_q   <= r0_sel_d;
      r0_cnt_q   <= r0_cnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (r0_we) r0_mem_q[r0_cnt_q[R0_AW-1:0]] <= word;
  end

endmodule

// File: tb/tb_core_msg_rx.sv
// Directed bench for core_msg_rx with an instruction scoreboard.
// Expected issue order is queued at push time; a negedge monitor checks it.
module tb_core_msg_rx;

  localparam logic [3:0] S_CM = 4'b1000;
  localparam logic [3:0] S_RM = 4'b0100;
  localparam logic [3:0] S_R0 = 4'b0010;
  localparam logic [3:0] S_IN = 4'b0001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] mess_to_core = '0;
  logic        core_mask_loading = 1'b0;
  logic        r0_mask_loading = 1'b0;
  logic        r0_loading = 1'b0;
  logic        instr_loading = 1'b0;
  logic        core_reading, core_ready;
  logic [15:0] instr_data;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        exec_done = 1'b0;
  logic [2:0]  r0_rd_addr = '0;
  logic [15:0] r0_rd_data;
  logic [3:0]  r0_cnt;
  logic [2:0]  err;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  core_msg_rx #(
    .CORE_ID     (3),
    .BUS_TO_CORE (16),
    .INSTR_DEPTH (32),
    .R0_DEPTH    (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .mess_to_core      (mess_to_core),
    .core_mask_loading (core_mask_loading),
    .r0_mask_loading   (r0_mask_loading),
    .r0_loading        (r0_loading),
    .instr_loading     (instr_loading),
    .core_reading      (core_reading),
    .core_ready        (core_ready),
    .instr_data        (instr_data),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .exec_done         (exec_done),
    .r0_rd_addr        (r0_rd_addr),
    .r0_rd_data        (r0_rd_data),
    .r0_cnt            (r0_cnt),
    .err               (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Handshake seen at negedge completes at the following posedge.
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", 32'(instr_data), 32'hDEAD);
      end else begin
        chk("issue_data", 32'(instr_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [3:0] s, input logic [15:0] w);
    {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = s;
    mess_to_core = w;
    @(posedge clk);
    #1;
    {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = '0;
    mess_to_core = '0;
  endtask

  task automatic instr(input logic [15:0] w, input bit expect_issue);
    if (expect_issue) exp_q.push_back(w);
    send(S_IN, w);
  endtask

  task automatic do_reset(input int n);
    instr_ready = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || instr_valid); i++)
      @(posedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    do_reset(2);
    chk("rst_core_ready", 32'(core_ready), 32'd1);
    chk("rst_core_reading", 32'(core_reading), 32'd1);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_data", 32'(instr_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_r0_cnt", 32'(r0_cnt), 32'd0);

    // r0 load
    send(S_CM, 16'h0008);
    chk("load_core_ready", 32'(core_ready), 32'd0);
    send(S_RM, 16'h0008);
    for (int i = 1; i <= 5; i++) send(S_R0, 16'hA000 + 16'(i));
    chk("r0_cnt5", 32'(r0_cnt), 32'd5);
    r0_rd_addr = 3'd4;
    #1;
    chk("r0_word4", 32'(r0_rd_data), 32'hA005);
    r0_rd_addr = 3'd0;
    #1;
    chk("r0_word0", 32'(r0_rd_data), 32'hA001);
    chk("r0_err", 32'(err), 32'd0);

    // task issue and completion
    do_reset(1);
    send(S_CM, 16'h0008);
    instr(16'h1111, 1'b1);
    instr(16'h2222, 1'b1);
    instr(16'hF000, 1'b0);
    chk("fin_valid", 32'(instr_valid), 32'd1);
    exec_done = 1'b1;
    @(posedge clk);
    #1;
    exec_done = 1'b0;
    chk("done_nonempty_ignored", 32'(core_ready), 32'd0);
    chk("fin_reading", 32'(core_reading), 32'd1);
    instr_ready = 1'b1;
    drain("drain_task");
    exec_done = 1'b1;
    @(posedge clk);
    #1;
    exec_done = 1'b0;
    chk("idle_core_ready", 32'(core_ready), 32'd1);
    chk("idle_core_reading", 32'(core_reading), 32'd1);

    // FIFO fill, backpressure and overflow
    do_reset(1);
    send(S_CM, 16'h0008);
    for (int i = 0; i < 29; i++) instr(16'h0100 + 16'(i), 1'b1);
    chk("reading_at29", 32'(core_reading), 32'd1);
    instr(16'h011D, 1'b1);
    chk("reading_at30", 32'(core_reading), 32'd0);
    instr(16'h011E, 1'b1);
    instr(16'h011F, 1'b1);
    chk("full_err_none", 32'(err), 32'd0);
    instr(16'h0555, 1'b0);
    chk("ovf_err", 32'(err), 32'b010);
    instr_ready = 1'b1;
    instr(16'h0777, 1'b1);
    chk("full_pop_push_err", 32'(err), 32'b010);
    drain("drain_full");
    instr_ready = 1'b0;

    // foreign mask, idle strobes, collision
    do_reset(1);
    send(S_CM, 16'h0004);
    chk("foreign_ready", 32'(core_ready), 32'd1);
    send(S_IN, 16'h1234);
    send(S_R0, 16'h4321);
    chk("idle_instr_valid", 32'(instr_valid), 32'd0);
    chk("idle_r0_cnt", 32'(r0_cnt), 32'd0);
    chk("idle_err", 32'(err), 32'd0);
    send(S_R0 | S_IN, 16'h1234);
    chk("coll_err", 32'(err), 32'b001);
    chk("coll_valid", 32'(instr_valid), 32'd0);

    // protocol error and r0 select/overflow
    send(S_CM, 16'h0008);
    chk("own_load", 32'(core_ready), 32'd0);
    send(S_CM, 16'h0008);
    chk("prot_err", 32'(err), 32'b101);
    send(S_RM, 16'h0000);
    send(S_R0, 16'hBEEF);
    chk("r0_unsel_cnt", 32'(r0_cnt), 32'd0);
    chk("r0_unsel_err", 32'(err), 32'b101);
    send(S_RM, 16'h0008);
    for (int i = 0; i < 9; i++) send(S_R0, 16'hB000 + 16'(i));
    chk("r0_full_cnt", 32'(r0_cnt), 32'd8);
    chk("r0_ovf_err", 32'(err), 32'b111);
    r0_rd_addr = 3'd7;
    #1;
    chk("r0_word7", 32'(r0_rd_data), 32'hB007);

    // reset mid-load
    do_reset(1);
    send(S_CM, 16'h0008);
    send(S_RM, 16'h0008);
    send(S_R0, 16'hC001);
    for (int i = 0; i < 10; i++) instr(16'h0200 + 16'(i), 1'b0);
    chk("mid_valid", 32'(instr_valid), 32'd1);
    chk("mid_r0_cnt", 32'(r0_cnt), 32'd1);
    do_reset(1);
    chk("rst_mid_valid", 32'(instr_valid), 32'd0);
    chk("rst_mid_ready", 32'(core_ready), 32'd1);
    chk("rst_mid_r0_cnt", 32'(r0_cnt), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
